// File: rtl/prbs_pkg.sv
// Shared definitions for the multi-polynomial PRBS generator:
// polynomial select, per-polynomial length/tap, FSM states.
package prbs_pkg;

    localparam int unsigned LFSR_W = 31;
    localparam int unsigned CTR_W  = 16;

    localparam int unsigned PRBS7_LEN  = 7;
    localparam int unsigned PRBS7_TAP  = 6;
    localparam int unsigned PRBS9_LEN  = 9;
    localparam int unsigned PRBS9_TAP  = 5;
    localparam int unsigned PRBS15_LEN = 15;
    localparam int unsigned PRBS15_TAP = 14;
    localparam int unsigned PRBS23_LEN = 23;
    localparam int unsigned PRBS23_TAP = 18;
    localparam int unsigned PRBS31_LEN = 31;
    localparam int unsigned PRBS31_TAP = 28;

    typedef enum logic [2:0] {
        PRBS7  = 3'd0,
        PRBS9  = 3'd1,
        PRBS15 = 3'd2,
        PRBS23 = 3'd3,
        PRBS31 = 3'd4
    } prbs_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN
    } prbs_state_e;

    function automatic prbs_mode_e to_mode(input logic [2:0] sel);
        prbs_mode_e m;
        case (sel)
            3'd0:    m = PRBS7;
            3'd1:    m = PRBS9;
            3'd2:    m = PRBS15;
            3'd3:    m = PRBS23;
            default: m = PRBS31;
        endcase
        return m;
    endfunction

    function automatic int unsigned mode_len(input prbs_mode_e m);
        int unsigned r;
        case (m)
            PRBS7:   r = PRBS7_LEN;
            PRBS9:   r = PRBS9_LEN;
            PRBS15:  r = PRBS15_LEN;
            PRBS23:  r = PRBS23_LEN;
            default: r = PRBS31_LEN;
        endcase
        return r;
    endfunction

    function automatic int unsigned mode_tap(input prbs_mode_e m);
        int unsigned r;
        case (m)
            PRBS7:   r = PRBS7_TAP;
            PRBS9:   r = PRBS9_TAP;
            PRBS15:  r = PRBS15_TAP;
            PRBS23:  r = PRBS23_TAP;
            default: r = PRBS31_TAP;
        endcase
        return r;
    endfunction

    function automatic logic [LFSR_W-1:0] mode_mask(input prbs_mode_e m);
        logic [31:0] w;
        w = (32'd1 << mode_len(m)) - 32'd1;
        return w[LFSR_W-1:0];
    endfunction

endpackage

// File: rtl/prbs_lfsr_step.sv
// Advances the Fibonacci LFSR by DATA_W steps in one combinational pass
// and assembles the output word, earliest bit in the MSB.
module prbs_lfsr_step
    import prbs_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [LFSR_W-1:0] state_i,
    input  prbs_mode_e        mode_i,
    input  logic              invert_i,
    output logic [LFSR_W-1:0] next_o,
    output logic [DATA_W-1:0] word_o
);

    logic [LFSR_W-1:0] mask;
    logic [LFSR_W-1:0] s;
    logic [4:0]        hi;
    logic [4:0]        lo;
    logic              nb;

    always_comb begin
        mask   = mode_mask(mode_i);
        hi     = 5'(mode_len(mode_i) - 1);
        lo     = 5'(mode_tap(mode_i) - 1);
        s      = state_i & mask;
        nb     = 1'b0;
        word_o = '0;
        for (int i = 0; i < DATA_W; i++) begin
            // all-zero register would lock up forever
            if (s == '0) s = mask;
            nb = s[hi] ^ s[lo];
            s  = {s[LFSR_W-2:0], nb} & mask;
            word_o[DATA_W-1-i] = nb ^ invert_i;
        end
        next_o = s;
    end

endmodule

// File: rtl/prbs_multi_gen.sv
// PRBS7/9/15/23/31 word generator with valid/ready output,
// periodic and on-demand single-bit error injection.
module prbs_multi_gen
    import prbs_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [2:0]        mode,
    input  logic              invert,
    input  logic [15:0]       err_interval,
    input  logic              inject,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  err_count,
    output logic              busy
);

    localparam int POS_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    prbs_state_e       state_q, state_d;
    prbs_mode_e        mode_q, mode_d;
    logic              inv_q, inv_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              corrupt_q, corrupt_d;
    logic [CTR_W-1:0]  cnt_q, cnt_d;
    logic [CTR_W-1:0]  ival_q;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              pend_q, pend_d;
    logic [CNT_W-1:0]  errc_q, errc_d;

    logic [LFSR_W-1:0] seed;
    logic [LFSR_W-1:0] step_next;
    prbs_mode_e        step_mode;
    logic              step_inv;
    logic [DATA_W-1:0] step_word;
    logic [DATA_W-1:0] flip;
    logic [CTR_W-1:0]  last;
    logic              acc;
    logic              gen;
    logic              per;
    logic              hit;

    assign acc  = valid_q & out_ready;
    assign last = err_interval - 16'd1;
    assign flip = DATA_W'(1) << pos_q;

    // LOAD seeds from all-ones using the live mode/invert inputs
    assign seed      = (state_q == ST_LOAD) ? '1 : lfsr_q;
    assign step_mode = (state_q == ST_LOAD) ? to_mode(mode) : mode_q;
    assign step_inv  = (state_q == ST_LOAD) ? invert : inv_q;

    prbs_lfsr_step #(
        .DATA_W(DATA_W)
    ) u_step (
        .state_i (seed),
        .mode_i  (step_mode),
        .invert_i(step_inv),
        .next_o  (step_next),
        .word_o  (step_word)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        inv_d     = inv_q;
        lfsr_d    = lfsr_q;
        data_d    = data_q;
        valid_d   = valid_q;
        corrupt_d = corrupt_q;
        pos_d     = pos_q;
        pend_d    = pend_q | inject;
        errc_d    = errc_q;
        gen       = 1'b0;

        cnt_d = cnt_q;
        if (err_interval == '0 || err_interval != ival_q) begin
            cnt_d = '0;
        end else if (acc) begin
            cnt_d = (cnt_q >= last) ? '0 : cnt_q + CTR_W'(1);
        end

        if (acc && corrupt_q && errc_q != '1) begin
            errc_d = errc_q + CNT_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                gen     = 1'b1;
                mode_d  = step_mode;
                inv_d   = step_inv;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!en) begin
                    if (acc) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (acc) begin
                    gen = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (acc) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // cnt_d is the counter value while the new word is presented
        per = (err_interval != '0) && (cnt_d == last);
        hit = per | pend_q | inject;

        if (gen) begin
            lfsr_d    = step_next;
            data_d    = step_word ^ (hit ? flip : '0);
            valid_d   = 1'b1;
            corrupt_d = hit;
            pend_d    = 1'b0;
            if (hit) begin
                pos_d = (pos_q == POS_W'(DATA_W - 1)) ? '0 : pos_q + POS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= PRBS7;
            inv_q     <= 1'b0;
            lfsr_q    <= '1;
            data_q    <= '0;
            valid_q   <= 1'b0;
            corrupt_q <= 1'b0;
            cnt_q     <= '0;
            ival_q    <= '0;
            pos_q     <= '0;
            pend_q    <= 1'b0;
            errc_q    <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            inv_q     <= inv_d;
            lfsr_q    <= lfsr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            corrupt_q <= corrupt_d;
            cnt_q     <= cnt_d;
            ival_q    <= err_interval;
            pos_q     <= pos_d;
            pend_q    <= pend_d;
            errc_q    <= errc_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign err_count = errc_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_prbs_multi_gen.sv
// Bench for prbs_multi_gen: bit-recurrence reference model,
// first-word table, random stalls, error injection, drain and reset.
module tb_prbs_multi_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en8, inv8, inj8, rdy8;
    logic [2:0]  mode8;
    logic [15:0] ival8;
    logic [7:0]  d8;
    logic        v8, busy8;
    logic [31:0] ec8;

    logic        en1, rdy1;
    logic [15:0] ival1;
    logic [0:0]  d1;
    logic        v1, busy1;
    logic [1:0]  ec1;

    prbs_multi_gen #(.DATA_W(8), .CNT_W(32)) u_dut8 (
        .clk(clk), .rst(rst), .en(en8), .mode(mode8), .invert(inv8),
        .err_interval(ival8), .inject(inj8), .out_data(d8),
        .out_valid(v8), .out_ready(rdy8), .err_count(ec8), .busy(busy8)
    );

    prbs_multi_gen #(.DATA_W(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .en(en1), .mode(3'd0), .invert(1'b0),
        .err_interval(ival1), .inject(1'b0), .out_data(d1),
        .out_valid(v1), .out_ready(rdy1), .err_count(ec1), .busy(busy1)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: b[n] = b[n-len] ^ b[n-tap], history starts all ones
    bit hist[$];
    int m_len, m_tap;
    bit m_inv;

    function automatic void model_init(input logic [2:0] md, input bit iv);
        case (md)
            3'd0: begin m_len = 7;  m_tap = 6;  end
            3'd1: begin m_len = 9;  m_tap = 5;  end
            3'd2: begin m_len = 15; m_tap = 14; end
            3'd3: begin m_len = 23; m_tap = 18; end
            default: begin m_len = 31; m_tap = 28; end
        endcase
        m_inv = iv;
        hist.delete();
        for (int i = 0; i < m_len; i++) hist.push_back(1'b1);
    endfunction

    function automatic bit model_bit();
        bit b;
        b = hist[hist.size() - m_len] ^ hist[hist.size() - m_tap];
        hist.push_back(b);
        if (hist.size() > 64) void'(hist.pop_front());
        return b ^ m_inv;
    endfunction

    function automatic logic [7:0] model_word8();
        logic [7:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w = {w[6:0], model_bit()};
        return w;
    endfunction

    logic       pv8, pr8, pv1, pr1, pd1;
    logic [7:0] pd8;

    task automatic tick();
        pv8 = v8; pr8 = rdy8; pd8 = d8;
        pv1 = v1; pr1 = rdy1; pd1 = d1[0];
        @(posedge clk);
        #1;
    endtask

    task automatic start8(input logic [2:0] md, input logic iv,
                          input logic [15:0] ival);
        ival8 = ival; mode8 = md; inv8 = iv;
        rdy8 = 1'b0; inj8 = 1'b0; en8 = 1'b0; en1 = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        en8 = 1'b1;
        tick();
        tick();
        model_init(md, iv);
    endtask

    logic [7:0] expw [0:31];

    task automatic run_err(input int ival, input int ia, input int ib,
                           input int chg_at, input int ival2,
                           input int nwords, input int ec_exp);
        logic [7:0] w;
        bit per;
        int p;
        start8(3'd0, 1'b0, 16'(ival));
        p = 0;
        for (int k = 1; k <= nwords; k++) begin
            w = model_word8();
            if (chg_at != 0 && k > chg_at) per = ((k - chg_at) % ival2) == 0;
            else per = (ival != 0) && (k % ival == 0);
            if (per || k == ia || k == ib) begin
                w[p] = ~w[p];
                p = (p + 1) % 8;
            end
            expw[k] = w;
        end
        rdy8 = 1'b1;
        for (int k = 1; k <= nwords; k++) begin
            inj8 = (k + 1 == ia) || (k + 1 == ib);
            if (chg_at != 0 && k == chg_at) ival8 = 16'(ival2);
            tick();
            inj8 = 1'b0;
            chk("err_word", 64'(pd8), 64'(expw[k]));
        end
        chk("err_count", 64'(ec8), 64'(ec_exp));
    endtask

    typedef struct {
        logic [2:0] mode;
        logic       inv;
        logic [7:0] first;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp;
        int nacc;
        logic rec128;

        tbl[0] = '{mode: 3'd0, inv: 1'b0, first: 8'h02};
        tbl[1] = '{mode: 3'd0, inv: 1'b1, first: 8'hFD};
        tbl[2] = '{mode: 3'd1, inv: 1'b0, first: 8'h07};
        tbl[3] = '{mode: 3'd1, inv: 1'b1, first: 8'hF8};
        tbl[4] = '{mode: 3'd2, inv: 1'b0, first: 8'h00};
        tbl[5] = '{mode: 3'd3, inv: 1'b1, first: 8'hFF};
        tbl[6] = '{mode: 3'd4, inv: 1'b0, first: 8'h00};
        tbl[7] = '{mode: 3'd6, inv: 1'b0, first: 8'h00};

        rst = 1'b0;
        en8 = 1'b1; inv8 = 1'b0; inj8 = 1'b0; rdy8 = 1'b1;
        mode8 = 3'd0; ival8 = 16'd0;
        en1 = 1'b0; rdy1 = 1'b0; ival1 = 16'd0;
        tick();
        tick();
        chk("rst_valid", 64'(v8), 64'(0));
        chk("rst_data", 64'(d8), 64'(0));
        chk("rst_errc", 64'(ec8), 64'(0));
        chk("rst_busy", 64'(busy8), 64'(0));

        // latency: LOAD on first edge after release, data on second
        rst = 1'b1;
        tick();
        chk("load_busy", 64'(busy8), 64'(1));
        chk("load_valid", 64'(v8), 64'(0));
        tick();
        chk("run_valid", 64'(v8), 64'(1));
        chk("run_first", 64'(d8), 64'(8'h02));

        foreach (tbl[t]) begin
            start8(tbl[t].mode, tbl[t].inv, 16'd0);
            chk("tbl_first", 64'(d8), 64'(tbl[t].first));
            mode8 = 3'($urandom_range(0, 7));
            inv8 = 1'($urandom_range(0, 1));
            rdy8 = 1'b1;
            exp = model_word8();
            for (int j = 0; j < 16; j++) begin
                tick();
                chk("tbl_stream", 64'(pd8), 64'(exp));
                exp = model_word8();
            end
        end

        start8(3'd4, 1'b0, 16'd0);
        exp = model_word8();
        nacc = 0;
        for (int i = 0; i < 300; i++) begin
            rdy8 = 1'($urandom_range(0, 1));
            mode8 = 3'($urandom_range(0, 7));
            inv8 = 1'($urandom_range(0, 1));
            tick();
            if (pr8) begin
                chk("prbs31_word", 64'(pd8), 64'(exp));
                exp = model_word8();
                nacc++;
            end else begin
                chk("stall_data", 64'(d8), 64'(exp));
                chk("stall_valid", 64'(v8), 64'(1));
            end
        end
        chk("prbs31_accepts", 64'(nacc >= 60), 64'(1));

        run_err(4, 0, 0, 0, 1, 12, 3);
        run_err(4, 4, 6, 0, 1, 8, 3);
        run_err(1, 0, 0, 0, 1, 10, 10);
        run_err(4, 0, 0, 2, 3, 12, 3);

        // drain path
        start8(3'd0, 1'b0, 16'd0);
        exp = model_word8();
        rdy8 = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("pre_drain", 64'(pd8), 64'(exp));
            exp = model_word8();
        end
        rdy8 = 1'b0;
        tick();
        en8 = 1'b0;
        tick();
        chk("drain_valid", 64'(v8), 64'(1));
        chk("drain_busy", 64'(busy8), 64'(1));
        chk("drain_data", 64'(d8), 64'(exp));
        tick();
        chk("drain_hold", 64'(d8), 64'(exp));
        rdy8 = 1'b1;
        tick();
        rdy8 = 1'b0;
        chk("drain_acc", 64'(pd8), 64'(exp));
        chk("drain_vfall", 64'(v8), 64'(0));
        chk("drain_idle", 64'(busy8), 64'(0));
        tick();
        chk("idle_stay", 64'(busy8), 64'(0));

        // en low while ready high leaves RUN directly
        start8(3'd1, 1'b0, 16'd0);
        rdy8 = 1'b1;
        en8 = 1'b0;
        tick();
        chk("run_idle_v", 64'(v8), 64'(0));
        chk("run_idle_b", 64'(busy8), 64'(0));

        // asynchronous reset in RUN
        start8(3'd0, 1'b0, 16'd2);
        rdy8 = 1'b1;
        for (int j = 0; j < 4; j++) tick();
        chk("pre_rst_errc", 64'(ec8), 64'(2));
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 64'(v8), 64'(0));
        chk("arst_errc", 64'(ec8), 64'(0));
        chk("arst_busy", 64'(busy8), 64'(0));
        mode8 = 3'd1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        tick();
        chk("post_rst_v", 64'(v8), 64'(1));
        chk("post_rst_word", 64'(d8), 64'(8'h07));
        en8 = 1'b0;

        // DATA_W=1 PRBS7 full period
        rst = 1'b0;
        ival1 = 16'd0;
        tick();
        rst = 1'b1;
        en1 = 1'b1;
        rdy1 = 1'b1;
        tick();
        tick();
        model_init(3'd0, 1'b0);
        rec128 = 1'b0;
        for (int i = 1; i <= 128; i++) begin
            tick();
            if (i <= 127) chk("prbs7_bit", 64'(pd1), 64'(model_bit()));
            else rec128 = pd1;
        end
        chk("prbs7_wrap", 64'(rec128), 64'(0));

        // CNT_W=2 counter saturates
        rst = 1'b0;
        ival1 = 16'd1;
        tick();
        rst = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("sat_two", 64'(ec1), 64'(2));
        for (int i = 0; i < 4; i++) tick();
        chk("sat_hold", 64'(ec1), 64'(3));
        en1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
